// File: rtl/branch_issue_arbiter_pkg.sv
// Shared decode helpers, CSR micro-op constants and FSM state type for the
// branch-resolver issue arbiter.
package branch_issue_arbiter_pkg;

  localparam logic [4:0] UOP_CSRRW  = 5'b11000;
  localparam logic [4:0] UOP_CSRRS  = 5'b11001;
  localparam logic [4:0] UOP_CSRRC  = 5'b11010;
  localparam logic [4:0] UOP_CSRRWI = 5'b11011;
  localparam logic [4:0] UOP_CSRRSI = 5'b11100;
  localparam logic [4:0] UOP_CSRRCI = 5'b11101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CSR_WAIT,
    ST_CSR_ISSUE,
    ST_CSR_DRAIN
  } csr_state_e;

  function automatic logic is_csr_op(input logic [4:0] uop);
    return uop[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/rr_starve_picker.sv
// Round-robin one-hot picker with a starvation override: any starved eligible
// requester beats the round-robin order, lowest index first.
module rr_starve_picker #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [N-1:0]     starved_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] cand;
  logic         found;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr_i));
    end

    // Requesters at or after the pointer first; otherwise wrap to the bottom.
    if (|(starved_i & eligible_i))      cand = starved_i & eligible_i;
    else if (|(eligible_i & hi_mask))   cand = eligible_i & hi_mask;
    else                                cand = eligible_i;

    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && cand[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_issue_arbiter.sv
// Registered issue stage sharing the branch resolver between REQ_N requesters,
// with round-robin/starvation arbitration and serialized, non-speculative CSR ops.
module branch_issue_arbiter
  import branch_issue_arbiter_pkg::*;
#(
  parameter int REQ_N      = 2,
  parameter int PAYLOAD_W  = 128,
  parameter int TICKET_W   = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REQ_N-1:0]                  req_valid,
  output logic [REQ_N-1:0]                  req_ready,
  input  logic [REQ_N-1:0][4:0]             req_microop,
  input  logic [REQ_N-1:0][TICKET_W-1:0]    req_ticket,
  input  logic [REQ_N-1:0][PAYLOAD_W-1:0]   req_payload,
  input  logic [TICKET_W-1:0]               head_ticket,
  input  logic                              flush,
  input  logic                              fu_busy,
  output logic                              out_valid,
  output logic [4:0]                        out_microop,
  output logic [TICKET_W-1:0]               out_ticket,
  output logic [PAYLOAD_W-1:0]              out_payload,
  output logic                              csr_active
);

  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  csr_state_e           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     starve_q [REQ_N];
  logic [CNT_W-1:0]     starve_d [REQ_N];
  logic                 out_valid_q, out_valid_d;
  logic [4:0]           out_microop_q, out_microop_d;
  logic [TICKET_W-1:0]  out_ticket_q, out_ticket_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

  logic [REQ_N-1:0] csr_req, at_head, eligible, starved, pick;
  logic             issue_open, grant_opp, accept, csr_accept, csr_blocked, csr_pending;

  // Both op classes may only issue in IDLE or CSR_WAIT; CSRs additionally need the ROB head.
  assign issue_open = (state_q == ST_IDLE) || (state_q == ST_CSR_WAIT);
  assign grant_opp  = ~fu_busy & ~flush & ~rst;

  always_comb begin
    csr_req  = '0;
    at_head  = '0;
    eligible = '0;
    starved  = '0;
    for (int i = 0; i < REQ_N; i++) begin
      csr_req[i] = is_csr_op(req_microop[i]);
      at_head[i] = (req_ticket[i] == head_ticket);
      eligible[i] = csr_req[i] ? (req_valid[i] & issue_open & at_head[i])
                               : (req_valid[i] & issue_open);
      starved[i] = (starve_q[i] == CNT_W'(STARVE_MAX));
    end
  end

  rr_starve_picker #(.N(REQ_N)) u_picker (
    .eligible_i (eligible),
    .starved_i  (starved),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick)
  );

  assign req_ready   = grant_opp ? pick : '0;
  assign accept      = |req_ready;
  assign csr_accept  = |(req_ready & csr_req);
  assign csr_blocked = |(req_valid & csr_req & ~at_head);
  assign csr_pending = |(req_valid & csr_req);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (csr_accept)                 state_d = ST_CSR_ISSUE;
                    else if (csr_blocked)           state_d = ST_CSR_WAIT;
      ST_CSR_WAIT:  if (csr_accept)                 state_d = ST_CSR_ISSUE;
                    else if (!csr_pending)          state_d = ST_IDLE;
      ST_CSR_ISSUE: if (out_valid_q && !fu_busy)    state_d = ST_CSR_DRAIN;
      ST_CSR_DRAIN:                                 state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    out_microop_d = out_microop_q;
    out_ticket_d  = out_ticket_q;
    out_payload_d = out_payload_q;

    for (int i = 0; i < REQ_N; i++) begin
      starve_d[i] = starve_q[i];
      if (flush || !req_valid[i] || req_ready[i]) starve_d[i] = '0;
      else if (eligible[i] && !starved[i])        starve_d[i] = starve_q[i] + 1'b1;

      if (req_ready[i]) begin
        rr_ptr_d      = (i == REQ_N - 1) ? '0 : PTR_W'(i + 1);
        out_microop_d = req_microop[i];
        out_ticket_d  = req_ticket[i];
        out_payload_d = req_payload[i];
      end
    end

    if (flush)         out_valid_d = 1'b0;
    else if (accept)   out_valid_d = 1'b1;
    else if (!fu_busy) out_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_microop_q <= '0;
      out_ticket_q  <= '0;
      out_payload_q <= '0;
      for (int i = 0; i < REQ_N; i++) starve_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_microop_q <= out_microop_d;
      out_ticket_q  <= out_ticket_d;
      out_payload_q <= out_payload_d;
      for (int i = 0; i < REQ_N; i++) starve_q[i] <= starve_d[i];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_microop = out_microop_q;
  assign out_ticket  = out_ticket_q;
  assign out_payload = out_payload_q;
  assign csr_active  = (state_q != ST_IDLE);

endmodule
